seg_scan_display: RTL and testbench
===================================

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 3: number of multiplexed digits, range 1..8.
REQ-002 SHALL have parameter VALUE_W, default 8: binary input width, range 1..27.
REQ-003 SHALL have parameter SCAN_DIV, default 4: clk cycles each digit is driven, minimum 1.
REQ-004 SHALL have parameter BLANK_CYCLES, default 200: zero-display hold time after empty, minimum 1.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge; one clock, reset is synchronous and active-high.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit: in_value is offered.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts a value this cycle.
REQ-009 SHALL have port in_value, input, VALUE_W bits: unsigned binary value to display.
REQ-010 SHALL have port lz_en, input, 1 bit: leading-zero suppression enable.
REQ-011 SHALL have port empty, input, 1 bit: battery-empty indication.
REQ-012 SHALL have port seg, output, 7 bits: segments a..g, MSB = a, 1 = lit.
REQ-013 SHALL have port digit_sel, output, NUM_DIGITS bits: one-hot digit enable, bit 0 = least significant digit.
REQ-014 SHALL have port overflow, output, 1 bit: displayed value exceeds 10^NUM_DIGITS-1.

Function
REQ-015 Accept SHALL occur on a cycle with in_valid=1 and in_ready=1; in_valid with in_ready=0 SHALL be ignored, with no queueing.
REQ-016 Load FSM states SHALL be IDLE (in_ready=1) and CONV (in_ready=0); accept SHALL move IDLE to CONV.
REQ-017 CONV SHALL run sequential double-dabble, one shift per cycle, for exactly VALUE_W cycles, producing NUM_DIGITS*4 BCD bits.
REQ-018 On the last CONV cycle, the display register and overflow SHALL update and the FSM SHALL return to IDLE, so a value accepted at cycle t is displayed from t+VALUE_W+1.
REQ-019 The next accept SHALL be possible at t+VALUE_W+1.
REQ-020 overflow SHALL be set when the accepted value exceeds 10^NUM_DIGITS-1, compared on the full VALUE_W value.
REQ-021 While overflow=1, every digit SHALL show dash 0000001, regardless of lz_en.
REQ-022 Scan counter SHALL count 0..SCAN_DIV-1; on wrap, the digit index SHALL advance and wrap from NUM_DIGITS-1 to 0.
REQ-023 digit_sel SHALL be exactly one-hot at all times after reset.
REQ-024 seg SHALL be registered and always correspond to the digit enabled by digit_sel in the same cycle.
REQ-025 Encoding SHALL be: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, blank=0000000.
REQ-026 With lz_en=1, digits above the most significant nonzero digit SHALL show blank; digit 0 SHALL always be shown.
REQ-027 Empty FSM states SHALL be NORMAL, HOLD_ZERO and OFF.
REQ-028 NORMAL SHALL move to HOLD_ZERO when empty=1, clearing the hold timer.
REQ-029 HOLD_ZERO SHALL show "0" on every digit, ignoring lz_en and overflow, for BLANK_CYCLES cycles, then move to OFF.
REQ-030 OFF SHALL output seg=0000000; scanning SHALL continue.
REQ-031 empty=0 in HOLD_ZERO or OFF SHALL return to NORMAL on the next cycle and clear the timer; the stored value SHALL be shown again.
REQ-032 Loads SHALL continue to be accepted and converted in any empty state, and take effect on return to NORMAL.
REQ-033 If empty and accept occur on the same cycle, both SHALL take effect independently.

Reset
REQ-034 rst=1 SHALL force: load FSM IDLE, in_ready=1, display register 0, overflow=0, empty FSM NORMAL, timer 0, scan counter 0, digit index 0, digit_sel = 1 (digit 0), seg=0000000.
REQ-035 rst asserted mid-CONV SHALL abort the conversion; the partial result SHALL be discarded and the display register SHALL be 0.

Structure
REQ-036 Shared package seg_disp_pkg SHALL hold the segment encoding function, SEG_BLANK, SEG_DASH and the load/empty FSM state encodings.
REQ-037 The double-dabble engine SHALL be sub-module bin2bcd_seq (start/done, parametrised VALUE_W, NUM_DIGITS).
REQ-038 Scan, lz logic and empty FSM SHALL remain in seg_scan_display.

Verification (NUM_DIGITS=3, VALUE_W=8, SCAN_DIV=4, BLANK_CYCLES=200 unless stated)
REQ-039 Load 157 at cycle t -> in_ready=0 for t+1..t+8; from t+9: digit_sel 001/seg 1110000, 010/1011011, 100/0110000, each held 4 cycles.
REQ-040 Load 5 with lz_en=1 -> digit 0 = 1011011, digits 1,2 = 0000000; switch lz_en=0 -> digits 1,2 = 1111110 on the next scan.
REQ-041 NUM_DIGITS=2: load 100 -> overflow=1, both digits 0000001; then load 99 -> overflow=0, both digits 1111011.
REQ-042 With 157 shown, raise empty -> 200 cycles all digits 1111110, then 0000000; drop empty -> 157 shown on the next cycle.
REQ-043 Pulse in_valid with 42 during CONV of 157 -> 42 ignored, 157 shown; rst at CONV cycle 4 -> in_ready=1 and digit 0 = 1111110 after reset.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// -----------------------------------------------------------------------------
// seg_disp_pkg
// Shared definitions for the multiplexed seven-segment display block:
//   - segment constants (blank, dash) and the digit-to-segment encoder
//   - load FSM and empty FSM state encodings
//   - pow10 helper used to derive the overflow threshold
// Segment vectors are ordered a..g with a in the MSB; 1 = segment lit.
// -----------------------------------------------------------------------------
package seg_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;

  typedef enum logic {
    LOAD_IDLE = 1'b0,
    LOAD_CONV = 1'b1
  } load_state_t;

  typedef enum logic [1:0] {
    EMPTY_NORMAL    = 2'b00,
    EMPTY_HOLD_ZERO = 2'b01,
    EMPTY_OFF       = 2'b10
  } empty_state_t;

  // Decimal digit to segment pattern; non-decimal codes render blank.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'b1111110;
      4'd1:    pattern = 7'b0110000;
      4'd2:    pattern = 7'b1101101;
      4'd3:    pattern = 7'b1111001;
      4'd4:    pattern = 7'b0110011;
      4'd5:    pattern = 7'b1011011;
      4'd6:    pattern = 7'b1011111;
      4'd7:    pattern = 7'b1110000;
      4'd8:    pattern = 7'b1111111;
      4'd9:    pattern = 7'b1111011;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

  // 10^n for elaboration-time constants (n <= 9 fits in 32 bits).
  function automatic logic [31:0] pow10(input int n);
    logic [31:0] acc;
    acc = 32'd1;
    for (int i = 0; i < n; i++) begin
      acc = acc * 32'd10;
    end
    return acc;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter: one add-3/shift step per clock, exactly
// VALUE_W steps per conversion.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (aborts a conversion)
//   i_start    : load i_bin and begin converting (ignored while busy)
//   i_bin      : unsigned binary input
//   o_done     : high during the final step; o_bcd is the result in that cycle
//   o_bcd      : NUM_DIGITS packed BCD nibbles, digit 0 in the low nibble
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
  parameter int VALUE_W    = 8,
  parameter int NUM_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [VALUE_W-1:0]      i_bin,
  output logic                    o_done,
  output logic [NUM_DIGITS*4-1:0] o_bcd
);

  localparam int BCD_W = NUM_DIGITS * 4;
  localparam int CNT_W = $clog2(VALUE_W + 1);

  logic [VALUE_W-1:0] r_bin;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_shifted;

  // Add-3 correction on every nibble >= 5, then shift in the next binary MSB.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) begin
        w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
      end else begin
        w_adj[i*4 +: 4] = r_bcd[i*4 +: 4];
      end
    end
    w_shifted = {w_adj[BCD_W-2:0], r_bin[VALUE_W-1]};
  end

  // The result is taken straight from the last step so the caller sees it
  // in the same cycle o_done is high.
  assign o_done = r_busy && (r_cnt == CNT_W'(VALUE_W - 1));
  assign o_bcd  = w_shifted;

  // Conversion state: load on start, one step per cycle while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin  <= {VALUE_W{1'b0}};
      r_bcd  <= {BCD_W{1'b0}};
      r_cnt  <= {CNT_W{1'b0}};
      r_busy <= 1'b0;
    end else if (i_start && !r_busy) begin
      r_bin  <= i_bin;
      r_bcd  <= {BCD_W{1'b0}};
      r_cnt  <= {CNT_W{1'b0}};
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_bin <= r_bin << 1;
      r_bcd <= w_shifted;
      if (o_done) begin
        r_busy <= 1'b0;
        r_cnt  <= {CNT_W{1'b0}};
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seg_scan_display.sv
// -----------------------------------------------------------------------------
// seg_scan_display
// Accepts a binary value, converts it to BCD and scans it onto a multiplexed
// seven-segment display, with leading-zero suppression, overflow dashes and a
// battery-empty sequence (hold "0" for BLANK_CYCLES, then dark).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : in_value offered; accepted when in_ready is also high
//   in_ready   : high while no conversion is running
//   in_value   : unsigned binary value to display
//   lz_en      : leading-zero suppression enable
//   empty      : battery-empty indication
//   seg        : segments a..g (MSB = a), 1 = lit, registered
//   digit_sel  : one-hot digit enable, bit 0 = least significant digit
//   overflow   : displayed value does not fit in NUM_DIGITS decimal digits
// seg and digit_sel are both registered from the same next-state values, so
// the pattern on seg always belongs to the digit currently enabled.
// -----------------------------------------------------------------------------
module seg_scan_display
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 3,
  parameter int VALUE_W      = 8,
  parameter int SCAN_DIV     = 4,
  parameter int BLANK_CYCLES = 200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [VALUE_W-1:0]    in_value,
  input  logic                  lz_en,
  input  logic                  empty,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  overflow
);

  localparam int          BCD_W   = NUM_DIGITS * 4;
  localparam int          IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int          SCNT_W  = $clog2(SCAN_DIV + 1);
  localparam int          TMR_W   = $clog2(BLANK_CYCLES + 1);
  localparam logic [31:0] MAX_VAL = pow10(NUM_DIGITS) - 32'd1;

  load_state_t           r_load_state, w_load_next;
  empty_state_t          r_estate, w_estate_next;
  logic [BCD_W-1:0]      r_disp, w_disp_next;
  logic                  r_ovf, w_ovf_next;
  logic                  r_ovf_pend, w_ovf_pend_next;
  logic [TMR_W-1:0]      r_timer, w_timer_next;
  logic [SCNT_W-1:0]     r_scan_cnt, w_scan_next;
  logic [IDX_W-1:0]      r_digit_idx, w_idx_next;
  logic [NUM_DIGITS-1:0] r_digit_sel;
  logic [6:0]            r_seg, w_seg_next;
  logic                  w_accept, w_done;
  logic [BCD_W-1:0]      w_bcd;
  logic [NUM_DIGITS-1:0] w_blank_mask;
  logic                  w_upper_zero;
  logic [3:0]            w_digit;
  logic                  w_lz_blank;

  assign in_ready  = (r_load_state == LOAD_IDLE);
  assign w_accept  = in_valid && (r_load_state == LOAD_IDLE);
  assign seg       = r_seg;
  assign digit_sel = r_digit_sel;
  assign overflow  = r_ovf;

  bin2bcd_seq #(
    .VALUE_W    (VALUE_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_accept),
    .i_bin   (in_value),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  // Load FSM plus display/overflow update at the end of a conversion.
  // Overflow is judged on the full binary value at accept time, since the
  // truncated BCD result cannot tell us.
  always_comb begin
    w_load_next     = r_load_state;
    w_disp_next     = r_disp;
    w_ovf_next      = r_ovf;
    w_ovf_pend_next = r_ovf_pend;
    case (r_load_state)
      LOAD_IDLE: begin
        if (in_valid) begin
          w_load_next     = LOAD_CONV;
          w_ovf_pend_next = (32'(in_value) > MAX_VAL);
        end else begin
          w_load_next = LOAD_IDLE;
        end
      end
      LOAD_CONV: begin
        if (w_done) begin
          w_load_next = LOAD_IDLE;
          w_disp_next = w_bcd;
          w_ovf_next  = r_ovf_pend;
        end else begin
          w_load_next = LOAD_CONV;
        end
      end
      default: w_load_next = LOAD_IDLE;
    endcase
  end

  // Empty FSM: HOLD_ZERO lasts BLANK_CYCLES cycles, any empty=0 returns home.
  always_comb begin
    w_estate_next = r_estate;
    w_timer_next  = r_timer;
    case (r_estate)
      EMPTY_NORMAL: begin
        if (empty) begin
          w_estate_next = EMPTY_HOLD_ZERO;
          w_timer_next  = {TMR_W{1'b0}};
        end else begin
          w_estate_next = EMPTY_NORMAL;
        end
      end
      EMPTY_HOLD_ZERO: begin
        if (!empty) begin
          w_estate_next = EMPTY_NORMAL;
          w_timer_next  = {TMR_W{1'b0}};
        end else if (r_timer == TMR_W'(BLANK_CYCLES - 1)) begin
          w_estate_next = EMPTY_OFF;
          w_timer_next  = {TMR_W{1'b0}};
        end else begin
          w_timer_next = r_timer + TMR_W'(1);
        end
      end
      EMPTY_OFF: begin
        if (!empty) begin
          w_estate_next = EMPTY_NORMAL;
          w_timer_next  = {TMR_W{1'b0}};
        end else begin
          w_estate_next = EMPTY_OFF;
        end
      end
      default: begin
        w_estate_next = EMPTY_NORMAL;
        w_timer_next  = {TMR_W{1'b0}};
      end
    endcase
  end

  // Scan counter and digit index; the index advances when the counter wraps.
  always_comb begin
    w_scan_next = r_scan_cnt + SCNT_W'(1);
    w_idx_next  = r_digit_idx;
    if (r_scan_cnt == SCNT_W'(SCAN_DIV - 1)) begin
      w_scan_next = {SCNT_W{1'b0}};
      if (r_digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
        w_idx_next = {IDX_W{1'b0}};
      end else begin
        w_idx_next = r_digit_idx + IDX_W'(1);
      end
    end else begin
      w_idx_next = r_digit_idx;
    end
  end

  // Leading-zero mask: a digit is blankable when it and every digit above it
  // are zero; digit 0 is never blanked so a value of 0 still shows "0".
  always_comb begin
    w_upper_zero = 1'b1;
    w_blank_mask = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_upper_zero    = w_upper_zero && (w_disp_next[i*4 +: 4] == 4'd0);
      w_blank_mask[i] = w_upper_zero && (i > 0);
    end
    w_digit    = 4'(w_disp_next >> {w_idx_next, 2'b00});
    w_lz_blank = w_blank_mask[w_idx_next];
  end

  // Segment pattern for the digit that will be enabled next cycle.
  always_comb begin
    w_seg_next = SEG_BLANK;
    case (w_estate_next)
      EMPTY_HOLD_ZERO: w_seg_next = seg_encode(4'd0);
      EMPTY_OFF:       w_seg_next = SEG_BLANK;
      EMPTY_NORMAL: begin
        if (w_ovf_next) begin
          w_seg_next = SEG_DASH;
        end else if (lz_en && w_lz_blank) begin
          w_seg_next = SEG_BLANK;
        end else begin
          w_seg_next = seg_encode(w_digit);
        end
      end
      default: w_seg_next = SEG_BLANK;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_state <= LOAD_IDLE;
      r_disp       <= {BCD_W{1'b0}};
      r_ovf        <= 1'b0;
      r_ovf_pend   <= 1'b0;
      r_estate     <= EMPTY_NORMAL;
      r_timer      <= {TMR_W{1'b0}};
      r_scan_cnt   <= {SCNT_W{1'b0}};
      r_digit_idx  <= {IDX_W{1'b0}};
      r_digit_sel  <= NUM_DIGITS'(1);
      r_seg        <= SEG_BLANK;
    end else begin
      r_load_state <= w_load_next;
      r_disp       <= w_disp_next;
      r_ovf        <= w_ovf_next;
      r_ovf_pend   <= w_ovf_pend_next;
      r_estate     <= w_estate_next;
      r_timer      <= w_timer_next;
      r_scan_cnt   <= w_scan_next;
      r_digit_idx  <= w_idx_next;
      r_digit_sel  <= NUM_DIGITS'(1) << w_idx_next;
      r_seg        <= w_seg_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_display
// Two instances share one stimulus stream: A (3 digits, scan 4, blank 200)
// and B (2 digits, scan 3, blank 5). A behavioural model predicts every
// output of both on every cycle from the displayed decimal value, the scan
// position derived from elapsed cycles and the length of the current empty
// run. Directed scenarios add constant expectations on top.
// -----------------------------------------------------------------------------
module tb_seg_scan_display;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_value;
  logic       lz_en;
  logic       empty;
  logic       ready_a, ready_b, ovf_a, ovf_b;
  logic [6:0] seg_a, seg_b;
  logic [2:0] dsel_a;
  logic [1:0] dsel_b;

  int n_tests;
  int n_fail;

  seg_scan_display #(
    .NUM_DIGITS(3), .VALUE_W(8), .SCAN_DIV(4), .BLANK_CYCLES(200)
  ) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_a),
    .in_value(in_value), .lz_en(lz_en), .empty(empty),
    .seg(seg_a), .digit_sel(dsel_a), .overflow(ovf_a)
  );

  seg_scan_display #(
    .NUM_DIGITS(2), .VALUE_W(8), .SCAN_DIV(3), .BLANK_CYCLES(5)
  ) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_b),
    .in_value(in_value), .lz_en(lz_en), .empty(empty),
    .seg(seg_b), .digit_sel(dsel_b), .overflow(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int nd_of(input int k); return (k == 0) ? 3 : 2; endfunction
  function automatic int sd_of(input int k); return (k == 0) ? 4 : 3; endfunction
  function automatic int bc_of(input int k); return (k == 0) ? 200 : 5; endfunction

  function automatic int p10(input int n);
    int acc = 1;
    for (int i = 0; i < n; i++) acc = acc * 10;
    return acc;
  endfunction

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'b1111110;  1: return 7'b0110000;  2: return 7'b1101101;
      3: return 7'b1111001;  4: return 7'b0110011;  5: return 7'b1011011;
      6: return 7'b1011111;  7: return 7'b1110000;  8: return 7'b1111111;
      9: return 7'b1111011;  default: return 7'b0000000;
    endcase
  endfunction

  int   m_busy;     // conversion cycles still to go, 0 = ready
  int   m_pend;     // value being converted
  int   m_val;      // value on the display
  int   m_erun;     // consecutive cycles empty has been seen high (capped)
  int   m_cyc;      // clock edges since the last reset edge
  bit   m_lz;       // lz_en seen at the last edge
  bit   m_inrst;    // last edge was a reset edge
  bit   m_live;

  initial begin
    m_busy = 0; m_pend = 0; m_val = 0; m_erun = 0; m_cyc = 0;
    m_lz = 1'b0; m_inrst = 1'b1; m_live = 1'b0;
  end

  always @(posedge clk) begin
    m_live  <= 1'b1;
    m_inrst <= rst;
    m_lz    <= lz_en;
    if (rst) begin
      m_busy <= 0; m_val <= 0; m_erun <= 0; m_cyc <= 0;
    end else begin
      if (m_busy > 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) m_val <= m_pend;
      end else if (in_valid) begin
        m_pend <= int'(in_value);
        m_busy <= 8;
      end
      m_erun <= empty ? ((m_erun > 1000) ? m_erun : m_erun + 1) : 0;
      m_cyc  <= m_cyc + 1;
    end
  end

  function automatic int exp_idx(input int k);
    return (m_cyc / sd_of(k)) % nd_of(k);
  endfunction

  function automatic logic [6:0] exp_seg(input int k);
    int idx = exp_idx(k);
    if (m_inrst) return 7'b0000000;
    if (m_erun >= 1 && m_erun <= bc_of(k)) return 7'b1111110;
    if (m_erun > bc_of(k)) return 7'b0000000;
    if (m_val > p10(nd_of(k)) - 1) return 7'b0000001;
    if (m_lz && idx > 0 && m_val < p10(idx)) return 7'b0000000;
    return enc((m_val / p10(idx)) % 10);
  endfunction

  always @(negedge clk) begin
    if (m_live) begin
      check("seg_a",  32'(seg_a),  32'(exp_seg(0)));
      check("dsel_a", 32'(dsel_a), 32'(1) << exp_idx(0));
      check("rdy_a",  32'(ready_a), 32'(m_busy == 0));
      check("ovf_a",  32'(ovf_a),  32'(m_val > 999));
      check("seg_b",  32'(seg_b),  32'(exp_seg(1)));
      check("dsel_b", 32'(dsel_b), 32'(1) << exp_idx(1));
      check("rdy_b",  32'(ready_b), 32'(m_busy == 0));
      check("ovf_b",  32'(ovf_b),  32'(m_val > 99));
    end
  end

  // ---------------- directed helpers ----------------
  // Called at a negedge while idle; returns at the negedge of cycle t+9.
  task automatic load(input int v);
    in_valid = 1'b1;
    in_value = 8'(v);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("rdy_conv", 32'(ready_a), 32'd0);
      @(negedge clk);
    end
    check("rdy_back", 32'(ready_a), 32'd1);
  endtask

  // One full scan; each cycle the shown pattern must match the enabled digit.
  task automatic expect_scan(input string tag, input int k,
                             input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2);
    logic [6:0] s, e;
    logic [2:0] d;
    for (int c = 0; c < sd_of(k) * nd_of(k); c++) begin
      @(negedge clk);
      s = (k == 0) ? seg_a : seg_b;
      d = (k == 0) ? dsel_a : {1'b0, dsel_b};
      e = (d == 3'b001) ? e0 : (d == 3'b010) ? e1 : e2;
      check(tag, 32'(s), 32'(e));
    end
  endtask

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S9 = 7'b1111011;
  localparam logic [6:0] SD = 7'b0000001;
  localparam logic [6:0] SB = 7'b0000000;

  int run_left;

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; in_valid = 1'b0; in_value = 8'd0; lz_en = 1'b0; empty = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dsel", 32'(dsel_a), 32'd1);
    check("rst_seg",  32'(seg_a),  32'd0);
    rst = 1'b0;

    // 157 scanned as 7,5,1
    load(157);
    expect_scan("v157", 0, 7'b1110000, 7'b1011011, 7'b0110000);

    // leading-zero suppression on and off
    lz_en = 1'b1;
    load(5);
    expect_scan("lz5", 0, 7'b1011011, SB, SB);
    lz_en = 1'b0;
    expect_scan("nolz5", 0, 7'b1011011, S0, S0);

    // overflow on the two-digit instance
    load(100);
    expect_scan("ovf100", 1, SD, SD, SB);
    check("ovf_b100", 32'(ovf_b), 32'd1);
    load(99);
    expect_scan("v99", 1, S9, S9, SB);
    check("ovf_b99", 32'(ovf_b), 32'd0);

    // empty sequence with 157 shown
    load(157);
    empty = 1'b1;
    repeat (100) @(negedge clk);
    expect_scan("hold0", 0, S0, S0, S0);
    repeat (95) @(negedge clk);
    expect_scan("off", 0, SB, SB, SB);
    empty = 1'b0;
    expect_scan("back157", 0, 7'b1110000, 7'b1011011, 7'b0110000);

    // in_valid during conversion is dropped
    load(3);
    in_valid = 1'b1; in_value = 8'd157;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    in_valid = 1'b1; in_value = 8'd42;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("rdy_after", 32'(ready_a), 32'd1);
    expect_scan("ign42", 0, 7'b1110000, 7'b1011011, 7'b0110000);

    // reset in the 4th conversion cycle
    in_valid = 1'b1; in_value = 8'd157;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_rdy",  32'(ready_a), 32'd1);
    check("mrst_dsel", 32'(dsel_a),  32'd1);
    check("mrst_seg",  32'(seg_a),   32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_dsel", 32'(dsel_a), 32'd1);
    check("post_seg",  32'(seg_a),  32'(S0));
    expect_scan("post0", 0, S0, S0, S0);

    // randomized traffic against the model
    run_left = 20;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 2) == 0);
      in_value = 8'($urandom);
      if ($urandom_range(0, 49) == 0) lz_en = ~lz_en;
      if (run_left == 0) begin
        empty = ~empty;
        run_left = empty ? int'($urandom_range(1, 260)) : int'($urandom_range(5, 80));
      end else begin
        run_left--;
      end
      rst = ($urandom_range(0, 399) == 0);
    end
    rst = 1'b0; in_valid = 1'b0; empty = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
